// File: rtl/fetch_pkg.sv
// Shared widths, defaults and the buffer-entry payload type for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned ADDR_W        = 32;
  localparam int unsigned INSTR_W       = 32;
  localparam int unsigned BUF_DEPTH_DEF = 2;
  localparam int unsigned CNT_W         = 2;

  localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// ROM, redirect and consumer handshake signals of the fetch unit.
interface instr_fetch_if
  import fetch_pkg::*;
();

  logic [ADDR_W-1:0]  rom_addr;
  logic [INSTR_W-1:0] rom_instr;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               out_valid;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic               out_ready;

  modport master (
    output rom_addr,
    input  rom_instr,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    output out_instr,
    output out_pc,
    input  out_ready
  );

  modport slave (
    input  rom_addr,
    output rom_instr,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    input  out_instr,
    input  out_pc,
    output out_ready
  );

endinterface

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of fetched {pc, instr} pairs with single-cycle flush.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = BUF_DEPTH_DEF
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             push_i,
  input  fetch_entry_t     push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] count_o,
  output logic             head_valid_o,
  output fetch_entry_t     head_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  // Pointer/occupancy next state; flush wins over push and pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = ~wr_ptr_q;
      if (pop_i)  rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign count_o      = count_q;
  assign head_valid_o = (count_q != '0);
  assign head_o       = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch.sv
// Sequential instruction fetcher: drives a registered ROM, buffers returns, honours redirects.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = RESET_PC_DEF,
  parameter int unsigned       BUF_DEPTH = BUF_DEPTH_DEF
) (
  input logic           clock,
  input logic           rst_n,
  instr_fetch_if.master bus
);

  logic [ADDR_W-1:0] fetch_pc_q,    fetch_pc_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              inflight_q,    inflight_d;

  logic [CNT_W-1:0]  buf_count;
  logic              buf_head_valid;
  fetch_entry_t      buf_head;
  fetch_entry_t      push_data_c;
  logic              pop_c, push_c, issue_c;
  logic [CNT_W:0]    occupancy_c;

  // Issue only when the buffer can absorb everything already promised to it
  always_comb begin
    pop_c         = buf_head_valid & bus.out_ready & ~bus.redirect_valid;
    push_c        = inflight_q & ~bus.redirect_valid;
    occupancy_c   = (CNT_W+1)'(buf_count) + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop_c);
    issue_c       = ~bus.redirect_valid & (occupancy_c < (CNT_W+1)'(BUF_DEPTH));
    push_data_c.pc    = inflight_pc_q;
    push_data_c.instr = bus.rom_instr;

    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = 1'b0;
    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc;
    end else if (issue_c) begin
      inflight_d    = 1'b1;
      inflight_pc_d = fetch_pc_q;
      fetch_pc_d    = fetch_pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
    end
  end

  fetch_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clock        (clock),
    .rst_n        (rst_n),
    .push_i       (push_c),
    .push_data_i  (push_data_c),
    .pop_i        (pop_c),
    .flush_i      (bus.redirect_valid),
    .count_o      (buf_count),
    .head_valid_o (buf_head_valid),
    .head_o       (buf_head)
  );

  assign bus.rom_addr  = fetch_pc_q;
  assign bus.out_valid = buf_head_valid;
  assign bus.out_pc    = buf_head.pc;
  assign bus.out_instr = buf_head.instr;

endmodule
